// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, state encoding, control-word layout and decode helpers
// for the hardwired control unit.
package cpu_ctrl_pkg;

    localparam int OPC_W = 5;
    typedef logic [OPC_W-1:0] opc_t;

    localparam opc_t OP_LD   = 5'd0;
    localparam opc_t OP_LDI  = 5'd1;
    localparam opc_t OP_ST   = 5'd2;
    localparam opc_t OP_ADD  = 5'd3;
    localparam opc_t OP_SUB  = 5'd4;
    localparam opc_t OP_AND  = 5'd5;
    localparam opc_t OP_OR   = 5'd6;
    localparam opc_t OP_SHR  = 5'd7;
    localparam opc_t OP_SHL  = 5'd8;
    localparam opc_t OP_ROR  = 5'd9;
    localparam opc_t OP_ROL  = 5'd10;
    localparam opc_t OP_ADDI = 5'd11;
    localparam opc_t OP_ANDI = 5'd12;
    localparam opc_t OP_ORI  = 5'd13;
    localparam opc_t OP_MUL  = 5'd14;
    localparam opc_t OP_DIV  = 5'd15;
    localparam opc_t OP_NEG  = 5'd16;
    localparam opc_t OP_NOT  = 5'd17;
    localparam opc_t OP_BR   = 5'd18;
    localparam opc_t OP_JR   = 5'd19;
    localparam opc_t OP_JAL  = 5'd20;
    localparam opc_t OP_IN   = 5'd21;
    localparam opc_t OP_OUT  = 5'd22;
    localparam opc_t OP_MFHI = 5'd23;
    localparam opc_t OP_MFLO = 5'd24;
    localparam opc_t OP_NOP  = 5'd25;
    localparam opc_t OP_HALT = 5'd26;

    // T-states are consecutive so the sequencer can step with +1.
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic PCout, Zhighout, Zlowout, MDRout, HIOut, LOout, InPortout, Cout, BAOut, Rout;
        logic PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin;
        logic OutPortin, CONin, Rin;
        logic Gra, Grb, Grc;
        logic Read, Write;
        opc_t op;
    } ctrl_t;

    function automatic opc_t alu_op(input opc_t o);
        case (o)
            OP_ADDI: alu_op = OP_ADD;
            OP_ANDI: alu_op = OP_AND;
            OP_ORI:  alu_op = OP_OR;
            default: alu_op = o;
        endcase
    endfunction

    // Final execute state per opcode; T2 means there is no execute phase.
    function automatic state_t last_state(input opc_t o);
        case (o)
            OP_LD, OP_ST:                           last_state = S_T7;
            OP_LDI:                                 last_state = S_T5;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI:               last_state = S_T5;
            OP_MUL, OP_DIV, OP_BR:                  last_state = S_T6;
            OP_NEG, OP_NOT, OP_JAL:                 last_state = S_T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: last_state = S_T3;
            default:                                last_state = S_T2;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_signal_decode.sv
// Combinational control-word decode from (state, opcode, branchCompare).
module ctrl_signal_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t state_i,
    input  opc_t   opc_i,
    input  logic   br_cmp_i,
    output ctrl_t  cw_o
);

    logic is_imm;
    assign is_imm = (opc_i == OP_ADDI) || (opc_i == OP_ANDI) || (opc_i == OP_ORI);

    always_comb begin
        cw_o = '0;
        case (state_i)
            S_RST, S_HALT: ;
            S_T0: begin
                cw_o.PCout = 1'b1; cw_o.MARin = 1'b1; cw_o.IncPC = 1'b1;
                cw_o.ZHighin = 1'b1; cw_o.Zlowin = 1'b1;
            end
            S_T1: begin
                cw_o.Zlowout = 1'b1; cw_o.PCin = 1'b1; cw_o.Read = 1'b1; cw_o.MDRin = 1'b1;
            end
            S_T2: begin
                cw_o.MDRout = 1'b1; cw_o.IRin = 1'b1;
            end
            default: begin
                case (opc_i)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state_i)
                            S_T3: begin cw_o.Grb = 1'b1; cw_o.Rout = 1'b1; cw_o.Yin = 1'b1; end
                            S_T4: begin
                                if (is_imm) cw_o.Cout = 1'b1;
                                else begin cw_o.Grc = 1'b1; cw_o.Rout = 1'b1; end
                                cw_o.op = alu_op(opc_i);
                                cw_o.ZHighin = 1'b1; cw_o.Zlowin = 1'b1;
                            end
                            S_T5: begin cw_o.Zlowout = 1'b1; cw_o.Gra = 1'b1; cw_o.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state_i)
                            S_T3: begin
                                cw_o.Grb = 1'b1; cw_o.Rout = 1'b1; cw_o.op = opc_i;
                                cw_o.ZHighin = 1'b1; cw_o.Zlowin = 1'b1;
                            end
                            S_T4: begin cw_o.Zlowout = 1'b1; cw_o.Gra = 1'b1; cw_o.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state_i)
                            S_T3: begin cw_o.Gra = 1'b1; cw_o.Rout = 1'b1; cw_o.Yin = 1'b1; end
                            S_T4: begin
                                cw_o.Grb = 1'b1; cw_o.Rout = 1'b1; cw_o.op = opc_i;
                                cw_o.ZHighin = 1'b1; cw_o.Zlowin = 1'b1;
                            end
                            S_T5: begin cw_o.Zlowout = 1'b1; cw_o.LOin = 1'b1; end
                            S_T6: begin cw_o.Zhighout = 1'b1; cw_o.HIin = 1'b1; end
                            default: ;
                        endcase
                    end
                    // LD, LDI and ST share the effective-address computation in T3-T4.
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state_i)
                            S_T3: begin cw_o.Grb = 1'b1; cw_o.BAOut = 1'b1; cw_o.Yin = 1'b1; end
                            S_T4: begin
                                cw_o.Cout = 1'b1; cw_o.op = OP_ADD;
                                cw_o.ZHighin = 1'b1; cw_o.Zlowin = 1'b1;
                            end
                            S_T5: begin
                                cw_o.Zlowout = 1'b1;
                                if (opc_i == OP_LDI) begin cw_o.Gra = 1'b1; cw_o.Rin = 1'b1; end
                                else cw_o.MARin = 1'b1;
                            end
                            S_T6: begin
                                cw_o.MDRin = 1'b1;
                                if (opc_i == OP_ST) begin cw_o.Gra = 1'b1; cw_o.Rout = 1'b1; end
                                else cw_o.Read = 1'b1;
                            end
                            S_T7: begin
                                if (opc_i == OP_ST) cw_o.Write = 1'b1;
                                else begin cw_o.MDRout = 1'b1; cw_o.Gra = 1'b1; cw_o.Rin = 1'b1; end
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state_i)
                            S_T3: begin cw_o.Gra = 1'b1; cw_o.Rout = 1'b1; cw_o.CONin = 1'b1; end
                            S_T4: begin cw_o.PCout = 1'b1; cw_o.Yin = 1'b1; end
                            S_T5: begin
                                cw_o.Cout = 1'b1; cw_o.op = OP_ADD;
                                cw_o.ZHighin = 1'b1; cw_o.Zlowin = 1'b1;
                            end
                            S_T6: if (br_cmp_i) begin cw_o.Zlowout = 1'b1; cw_o.PCin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_JR: if (state_i == S_T3) begin
                        cw_o.Gra = 1'b1; cw_o.Rout = 1'b1; cw_o.PCin = 1'b1;
                    end
                    OP_JAL: begin
                        case (state_i)
                            S_T3: begin cw_o.PCout = 1'b1; cw_o.Grb = 1'b1; cw_o.Rin = 1'b1; end
                            S_T4: begin cw_o.Gra = 1'b1; cw_o.Rout = 1'b1; cw_o.PCin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_IN:   if (state_i == S_T3) begin cw_o.InPortout = 1'b1; cw_o.Gra = 1'b1; cw_o.Rin = 1'b1; end
                    OP_OUT:  if (state_i == S_T3) begin cw_o.Gra = 1'b1; cw_o.Rout = 1'b1; cw_o.OutPortin = 1'b1; end
                    OP_MFHI: if (state_i == S_T3) begin cw_o.HIOut = 1'b1; cw_o.Gra = 1'b1; cw_o.Rin = 1'b1; end
                    OP_MFLO: if (state_i == S_T3) begin cw_o.LOout = 1'b1; cw_o.Gra = 1'b1; cw_o.Rin = 1'b1; end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Hardwired fetch/decode/execute sequencer for data_path. State advances on the
// falling clock edge. Optional CTRL_MEM_WAIT_EN adds Mem_ready wait states.
module ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           Clock,
    input  logic           clear,
    input  logic [IRW-1:0] IR,
    input  logic           branchCompare,
`ifdef CTRL_MEM_WAIT_EN
    input  logic           Mem_ready,
`endif
    output logic PCout, Zhighout, Zlowout, MDRout, HIOut, LOout, InPortout, Cout, BAOut, Rout,
    output logic PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin,
    output logic OutPortin, CONin, Rin,
    output logic Gra, Grb, Grc,
    output logic Read, Write,
    output logic [OPW-1:0] op,
    output logic Run
);

    state_t state_q, state_d;
    opc_t   opc;
    ctrl_t  cw;
    logic   hold;
    logic   unused_ir;

    assign opc       = IR[IRW-1 -: OPW];
    assign unused_ir = ^IR[IRW-OPW-1:0];

    ctrl_signal_decode u_dec (
        .state_i  (state_q),
        .opc_i    (opc),
        .br_cmp_i (branchCompare),
        .cw_o     (cw)
    );

`ifdef CTRL_MEM_WAIT_EN
    assign hold = (cw.Read | cw.Write) & ~Mem_ready;
`else
    assign hold = 1'b0;
`endif

    always_ff @(negedge Clock or negedge clear) begin
        if (!clear) state_q <= S_RST;
        else        state_q <= state_d;
    end

    // IR is loaded during T2, so the opcode is valid when leaving T2.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: begin
                if (hold)                                   state_d = state_q;
                else if (state_q == S_T2 && opc == OP_HALT) state_d = S_HALT;
                else if (state_q == last_state(opc))        state_d = S_T0;
                else                                        state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    assign {PCout, Zhighout, Zlowout, MDRout, HIOut, LOout, InPortout, Cout, BAOut, Rout}
        = {cw.PCout, cw.Zhighout, cw.Zlowout, cw.MDRout, cw.HIOut, cw.LOout,
           cw.InPortout, cw.Cout, cw.BAOut, cw.Rout};
    assign {PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin}
        = {cw.PCin, cw.IncPC, cw.MARin, cw.MDRin, cw.IRin, cw.Yin,
           cw.ZHighin, cw.Zlowin, cw.HIin, cw.LOin};
    assign {OutPortin, CONin, Rin} = {cw.OutPortin, cw.CONin, cw.Rin};
    assign {Gra, Grb, Grc}         = {cw.Gra, cw.Grb, cw.Grc};
    assign {Read, Write}           = {cw.Read, cw.Write};
    assign op  = cw.op;
    assign Run = (state_q != S_RST) && (state_q != S_HALT);

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: per-state control words for several instruction
// classes, reset abort, HALT, and (with CTRL_MEM_WAIT_EN) memory wait states.
module tb_ctrl_unit;

    logic Clock, clear, branchCompare;
    logic [31:0] IR;
`ifdef CTRL_MEM_WAIT_EN
    logic Mem_ready;
`endif
    logic PCout, Zhighout, Zlowout, MDRout, HIOut, LOout, InPortout, Cout, BAOut, Rout;
    logic PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin;
    logic OutPortin, CONin, Rin, Gra, Grb, Grc, Read, Write, Run;
    logic [4:0] op;
    logic [27:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    ctrl_unit dut (
        .Clock(Clock), .clear(clear), .IR(IR), .branchCompare(branchCompare),
`ifdef CTRL_MEM_WAIT_EN
        .Mem_ready(Mem_ready),
`endif
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIOut(HIOut), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .BAOut(BAOut), .Rout(Rout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin),
        .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write), .op(op), .Run(Run)
    );

    assign obs = {Write, Read, Grc, Grb, Gra, Rin, CONin, OutPortin, LOin, HIin,
                  Zlowin, ZHighin, Yin, IRin, MDRin, MARin, IncPC, PCin,
                  Rout, BAOut, Cout, InPortout, LOout, HIOut, MDRout, Zlowout, Zhighout, PCout};

    localparam logic [27:0] B_PCout = 28'd1 << 0,  B_Zhighout = 28'd1 << 1,  B_Zlowout = 28'd1 << 2;
    localparam logic [27:0] B_MDRout = 28'd1 << 3, B_HIOut = 28'd1 << 4,     B_LOout = 28'd1 << 5;
    localparam logic [27:0] B_InPortout = 28'd1 << 6, B_Cout = 28'd1 << 7,   B_BAOut = 28'd1 << 8;
    localparam logic [27:0] B_Rout = 28'd1 << 9,   B_PCin = 28'd1 << 10,     B_IncPC = 28'd1 << 11;
    localparam logic [27:0] B_MARin = 28'd1 << 12, B_MDRin = 28'd1 << 13,    B_IRin = 28'd1 << 14;
    localparam logic [27:0] B_Yin = 28'd1 << 15,   B_ZHighin = 28'd1 << 16,  B_Zlowin = 28'd1 << 17;
    localparam logic [27:0] B_HIin = 28'd1 << 18,  B_LOin = 28'd1 << 19,     B_OutPortin = 28'd1 << 20;
    localparam logic [27:0] B_CONin = 28'd1 << 21, B_Rin = 28'd1 << 22,      B_Gra = 28'd1 << 23;
    localparam logic [27:0] B_Grb = 28'd1 << 24,   B_Grc = 28'd1 << 25,      B_Read = 28'd1 << 26;
    localparam logic [27:0] B_Write = 28'd1 << 27;

    localparam logic [27:0] M_Z  = B_ZHighin | B_Zlowin;
    localparam logic [27:0] M_T0 = B_PCout | B_MARin | B_IncPC | M_Z;
    localparam logic [27:0] M_T1 = B_Zlowout | B_PCin | B_Read | B_MDRin;
    localparam logic [27:0] M_T2 = B_MDRout | B_IRin;
    localparam logic [27:0] M_WB = B_Zlowout | B_Gra | B_Rin;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [27:0] m, input logic [4:0] o, input logic r);
        n_cmp++;
        assert (obs === m && op === o && Run === r) else begin
            n_bad++;
            $display("FAIL %s: got ctl=%h op=%h Run=%b, want ctl=%h op=%h Run=%b",
                     tag, obs, op, Run, m, o, r);
            $error("control word differs at %s", tag);
        end
    endtask

    task automatic step(input string tag, input logic [27:0] m, input logic [4:0] o);
        @(posedge Clock);
        chk(tag, m, o, 1'b1);
    endtask

    task automatic fetch();
        step("T1", M_T1, 5'd0);
        step("T2", M_T2, 5'd0);
    endtask

    // Waits at most two rising edges for the first fetch state after reset release.
    task automatic wait_t0(input string tag);
        for (int k = 0; k < 2; k++) begin
            @(posedge Clock);
            if (PCout === 1'b1) break;
        end
        chk(tag, M_T0, 5'd0, 1'b1);
    endtask

    // At most one bus driver may be asserted in any state.
    always @(posedge Clock) begin
        if (chk_en) begin
            n_cmp++;
            assert ($countones(obs[9:0]) <= 1) else begin
                n_bad++;
                $display("FAIL bus_onehot: got drivers=%b, want at most one set", obs[9:0]);
                $error("bus contention");
            end
        end
    end

    initial begin
        clear = 1'b1; IR = 32'hC800_0000; branchCompare = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
        Mem_ready = 1'b1;
`endif
        #1 clear = 1'b0;
        #1 chk("reset", 28'd0, 5'd0, 1'b0);
        chk_en = 1'b1;
        repeat (2) @(posedge Clock);
        clear = 1'b1;
        wait_t0("T0_after_reset");

        // ADD R1,R2,R3
        IR = 32'h1891_8000;
        fetch();
        step("ADD_T3", B_Grb | B_Rout | B_Yin, 5'd0);
        step("ADD_T4", B_Grc | B_Rout | M_Z, 5'd3);
        step("ADD_T5", M_WB, 5'd0);
        step("ADD_T0", M_T0, 5'd0);

        // LD R1,5(R2)
        IR = 32'h0090_0005;
        fetch();
        step("LD_T3", B_Grb | B_BAOut | B_Yin, 5'd0);
        step("LD_T4", B_Cout | M_Z, 5'd3);
        step("LD_T5", B_Zlowout | B_MARin, 5'd0);
        step("LD_T6", B_Read | B_MDRin, 5'd0);
        step("LD_T7", B_MDRout | B_Gra | B_Rin, 5'd0);
        step("LD_T0", M_T0, 5'd0);

        // BR taken
        IR = 32'h9000_0000; branchCompare = 1'b1;
        fetch();
        step("BR1_T3", B_Gra | B_Rout | B_CONin, 5'd0);
        step("BR1_T4", B_PCout | B_Yin, 5'd0);
        step("BR1_T5", B_Cout | M_Z, 5'd3);
        step("BR1_T6", B_Zlowout | B_PCin, 5'd0);
        step("BR1_T0", M_T0, 5'd0);

        // BR not taken: condition only matters in T6
        fetch();
        step("BR0_T3", B_Gra | B_Rout | B_CONin, 5'd0);
        step("BR0_T4", B_PCout | B_Yin, 5'd0);
        step("BR0_T5", B_Cout | M_Z, 5'd3);
        branchCompare = 1'b0;
        step("BR0_T6", 28'd0, 5'd0);
        step("BR0_T0", M_T0, 5'd0);

        // ADDI R1,R2,7
        IR = 32'h5890_0007;
        fetch();
        step("ADDI_T3", B_Grb | B_Rout | B_Yin, 5'd0);
        step("ADDI_T4", B_Cout | M_Z, 5'd3);
        step("ADDI_T5", M_WB, 5'd0);
        step("ADDI_T0", M_T0, 5'd0);

        // MUL R1,R2
        IR = 32'h7090_0000;
        fetch();
        step("MUL_T3", B_Gra | B_Rout | B_Yin, 5'd0);
        step("MUL_T4", B_Grb | B_Rout | M_Z, 5'd14);
        step("MUL_T5", B_Zlowout | B_LOin, 5'd0);
        step("MUL_T6", B_Zhighout | B_HIin, 5'd0);
        step("MUL_T0", M_T0, 5'd0);

        // ST 5(R2),R1
        IR = 32'h1090_0005;
        fetch();
        step("ST_T3", B_Grb | B_BAOut | B_Yin, 5'd0);
        step("ST_T4", B_Cout | M_Z, 5'd3);
        step("ST_T5", B_Zlowout | B_MARin, 5'd0);
        step("ST_T6", B_Gra | B_Rout | B_MDRin, 5'd0);
        step("ST_T7", B_Write, 5'd0);
        step("ST_T0", M_T0, 5'd0);

        // NOP: straight back to T0
        IR = 32'hC800_0000;
        fetch();
        step("NOP_T0", M_T0, 5'd0);

        // NEG, JAL, MFHI
        IR = 32'h8090_0000;
        fetch();
        step("NEG_T3", B_Grb | B_Rout | M_Z, 5'd16);
        step("NEG_T4", M_WB, 5'd0);
        step("NEG_T0", M_T0, 5'd0);
        IR = 32'hA090_0000;
        fetch();
        step("JAL_T3", B_PCout | B_Grb | B_Rin, 5'd0);
        step("JAL_T4", B_Gra | B_Rout | B_PCin, 5'd0);
        step("JAL_T0", M_T0, 5'd0);
        IR = 32'hB880_0000;
        fetch();
        step("MFHI_T3", B_HIOut | B_Gra | B_Rin, 5'd0);
        step("MFHI_T0", M_T0, 5'd0);

        // Abort LD in T6 with an asynchronous clear
        IR = 32'h0090_0005;
        fetch();
        repeat (3) @(posedge Clock);
        step("ABT_T6", B_Read | B_MDRin, 5'd0);
        #2 clear = 1'b0;
        #1 chk("abort_async", 28'd0, 5'd0, 1'b0);
        repeat (2) @(posedge Clock);
        chk("abort_held", 28'd0, 5'd0, 1'b0);
        clear = 1'b1;
        wait_t0("T0_after_abort");

        // HALT: idle until clear
        IR = 32'hD000_0000;
        fetch();
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            chk("halt", 28'd0, 5'd0, 1'b0);
        end
        IR = 32'hC800_0000;
        #2 clear = 1'b0;
        #2 clear = 1'b1;
        wait_t0("T0_after_halt");

`ifdef CTRL_MEM_WAIT_EN
        Mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("wait_T1_hold", M_T1, 5'd0);
        step("wait_T1_last", M_T1, 5'd0);
        Mem_ready = 1'b1;
        step("wait_T2", M_T2, 5'd0);
        step("wait_T0", M_T0, 5'd0);
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Hardwired control unit: the sequencer that drives the `data_path` control inputs, replacing stimulus-driven control.
- Fetches, decodes and executes one instruction at a time: T0–T2 fetch, T3–T7 execute.
- Consumes `irOut` and `branchCompare` from `data_path`; emits every register-enable, bus-select, memory and ALU-op control.

Parameters:
OPW, 5, opcode and ALU op width (`IR[31:27]`)
IRW, 32, instruction register width

Ports:
Clock  in  1  system clock
clear  in  1  asynchronous, active-low reset
IR  in  32  instruction from `irOut`; `ra`=`IR[26:23]`, `rb`=`IR[22:19]`, `rc`=`IR[18:15]`
branchCompare  in  1  CON flip-flop result from `data_path`
PCout, Zhighout, Zlowout, MDRout, HIOut, LOout, InPortout, Cout, BAOut, Rout  out  1 each  bus drivers
PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin, OutPortin, CONin, Rin  out  1 each  register enables
Gra, Grb, Grc  out  1 each  register-field selects
Read, Write  out  1 each  memory strobes
op  out  5  ALU operation
Run  out  1  high while executing; low in reset and HALT

Behaviour:
- Timing and reset:
  - State register updates on negedge `Clock`, offset from `data_path` posedge capture.
  - Outputs are Moore, decoded from state and `IR[31:27]`.
  - While `clear`=0: state is RST and all outputs are 0 asynchronously, `op`=0, `Run`=0.
  - After release: one negedge in RST, then T0 at the next negedge.
  - `clear` low mid-instruction aborts immediately; no partial write completes afterwards.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, ZHighin, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute; signals not listed are 0, and every sequence ends by returning to T0:
  - R-type (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL-free):
    - T3 Grb+Rout+Yin.
    - T4 Grc+Rout+op=opcode+ZHighin+Zlowin.
    - T5 Zlowout+Gra+Rin.
  - ADDI, ANDI, ORI: as R-type, but T4 uses Cout in place of Grc+Rout, with op = ADD, AND or OR code.
  - NEG, NOT:
    - T3 Grb+Rout+op+ZHighin+Zlowin.
    - T4 Zlowout+Gra+Rin.
  - MUL, DIV:
    - T3 Gra+Rout+Yin.
    - T4 Grb+Rout+op+ZHighin+Zlowin.
    - T5 Zlowout+LOin.
    - T6 Zhighout+HIin.
  - LD:
    - T3 Grb+BAOut+Yin.
    - T4 Cout+op=ADD+ZHighin+Zlowin.
    - T5 Zlowout+MARin.
    - T6 Read+MDRin.
    - T7 MDRout+Gra+Rin.
  - LDI: T3 and T4 as LD, then T5 Zlowout+Gra+Rin.
  - ST:
    - T3 to T5 as LD.
    - T6 Gra+Rout+MDRin (Read=0).
    - T7 Write.
  - BR:
    - T3 Gra+Rout+CONin.
    - T4 PCout+Yin.
    - T5 Cout+op=ADD+ZHighin+Zlowin.
    - T6: if `branchCompare`=1, Zlowout+PCin; otherwise all 0.
    - `branchCompare` is sampled only in T6.
  - JR: T3 Gra+Rout+PCin.
  - JAL: T3 PCout+Grb+Rin, T4 Gra+Rout+PCin.
  - IN, OUT, MFHI, MFLO (single T3 each):
    - IN: InPortout+Gra+Rin.
    - OUT: Gra+Rout+OutPortin.
    - MFHI: HIOut+Gra+Rin.
    - MFLO: LOout+Gra+Rin.
  - NOP and undefined opcodes: T2 goes directly to T0.
  - HALT: enters HALT with all outputs 0 and `Run`=0; only `clear` exits.
- At most one bus driver is asserted in any state; the bench checks this every cycle.

Optional Feature:
- Macro: CTRL_MEM_WAIT_EN.
- When defined:
  - Adds input `Mem_ready`.
  - Any state asserting Read or Write (T1, LD T6, ST T7) holds, with outputs unchanged, until `Mem_ready`=1 at the negedge.
  - `clear` still aborts the hold.
- When undefined: no port; memory is single-cycle and every state lasts exactly one cycle.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - Opcode constants: LD=0, LDI=1, ST=2, ADD=3, SUB=4, AND=5, OR=6, SHR=7, SHL=8, ROR=9, ROL=10, ADDI=11, ANDI=12, ORI=13, MUL=14, DIV=15, NEG=16, NOT=17, BR=18, JR=19, JAL=20, IN=21, OUT=22, MFHI=23, MFLO=24, NOP=25, HALT=26.
  - State encoding: RST, T0–T7, HALT.
  - ALU-op mapping: immediate opcode → register opcode.
- Sub-module `ctrl_signal_decode`: purely combinational (state, opcode, `branchCompare`) → control word. The top module holds the state register and the wait logic.

Test Plan:
- Reset: pull `clear` low during LD T6 → all outputs 0 and `Run`=0 with no clock edge; release → T0 within 2 negedges showing PCout, MARin, IncPC, ZHighin, Zlowin.
- ADD R1,R2,R3 (IR=0x18918000) → T3 Grb/Rout/Yin, T4 Grc/Rout/op=00011, T5 Zlowout/Gra/Rin; next T0 occurs 6 cycles after the previous T0.
- LD R1,5(R2) (IR=0x00900005) → T3 BAOut, T4 Cout with op=00011, T5 MARin, T6 Read+MDRin, T7 MDRout+Gra+Rin; 8-cycle instruction, Write never asserted.
- BR (IR=0x90000000):
  - `branchCompare`=1 → T6 Zlowout+PCin.
  - `branchCompare`=0 → T6 all-zero; both cases return to T0.
- HALT (IR=0xD0000000) → `Run`=0, all outputs 0 for 20 cycles; `clear` pulse → fetch resumes.
- With CTRL_MEM_WAIT_EN, `Mem_ready`=0 for 3 cycles during T1 → Read+MDRin held 4 cycles, then T2.
